// File: rtl/seg_bcd_formatter.sv
// seg_bcd_formatter: sequential double-dabble converter producing the 4-digit seven-segment nums word
// Ports: clk, rst (sync, active-high); start/value/neg request a conversion (sampled only in IDLE);
// busy is high during a conversion, done pulses when nums updates, nums = {BCD4,BCD3,BCD2,BCD1}.
module seg_bcd_formatter #(
    parameter int          WIDTH     = 14,
    parameter logic [15:0] ERR_CODE  = 16'hBEFF,
    parameter logic [15:0] IDLE_CODE = 16'hBBBB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic             busy,
    output logic             done,
    output logic [15:0]      nums
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [15:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_neg;
    logic             r_oor;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_nums;
    logic [15:0]      w_adj;
    logic             w_oor;
    // add-3 correction on every nibble before the shift
    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
    end
    // a negative value loses one digit to the leading '-'
    assign w_oor = (32'(value) > 32'd9999) || (neg && (32'(value) > 32'd999));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_oor   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nums  <= IDLE_CODE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_shift <= value;
                    r_neg   <= neg;
                    r_oor   <= w_oor;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    // bits shifted out above bit 15 only occur for out-of-range inputs
                    r_bcd   <= 16'({w_adj, r_shift[WIDTH-1]});
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 4'd1;
                    r_state <= (r_cnt == 4'(WIDTH - 1)) ? S_WRITE : S_CONV;
                end
                S_WRITE: begin
                    r_nums  <= r_oor ? ERR_CODE : (r_neg ? {4'hB, r_bcd[11:0]} : r_bcd);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign nums = r_nums;
endmodule
